seq_mult_datapath: RTL

SEQ_MULT_DATAPATH -- requirements
Module: seq_mult_datapath

---
 rtl/seq_mult_datapath_if.sv | 30 +++
 rtl/seq_mult_datapath.sv | 89 ++++++++
 2 files changed

// File: rtl/seq_mult_datapath_if.sv
// ============================================================================
// Module   : seq_mult_datapath_if
// Brief    : Operand/control and result bundle for the sequential multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_mult_datapath_if;
    logic        load_data;
    logic        shift_en;
    logic        extend;
    logic [7:0]  multiplicand_in;
    logic [7:0]  multiplier_in;
    logic        mult_done;
    logic        busy;
    logic [3:0]  step_count;
    logic [15:0] product;

    modport master (
        output load_data, shift_en, extend, multiplicand_in, multiplier_in,
        input  mult_done, busy, step_count, product
    );

    modport slave (
        input  load_data, shift_en, extend, multiplicand_in, multiplier_in,
        output mult_done, busy, step_count, product
    );
endinterface

`default_nettype wire

// File: rtl/seq_mult_datapath.sv
// ============================================================================
// Module   : seq_mult_datapath
// Brief    : 8x8 shift-add multiplier, signed or unsigned, one step per enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_mult_datapath (
    input  wire                  clk,
    input  wire                  rst,
    seq_mult_datapath_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  m_q,   m_d;
    logic [7:0]  q_q,   q_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pr_q,  pr_d;

    logic [15:0] w_ext;
    logic [15:0] w_addend;
    logic        w_last;

    assign w_ext    = bus.extend ? {{8{m_q[7]}}, m_q} : {8'd0, m_q};
    assign w_addend = q_q[0] ? (w_ext << cnt_q[2:0]) : 16'd0;
    assign w_last   = (cnt_q == 4'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            m_q     <= 8'd0;
            q_q     <= 8'd0;
            acc_q   <= 16'd0;
            cnt_q   <= 4'd0;
            pr_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;

        if (bus.load_data) begin
            m_d     = bus.multiplicand_in;
            q_d     = bus.multiplier_in;
            acc_d   = 16'd0;
            cnt_d   = 4'd0;
            state_d = S_RUN;
        end else if (state_q == S_RUN && bus.shift_en) begin
            // Bit 7 of a two's-complement multiplier carries negative weight.
            if (w_last && bus.extend)
                acc_d = acc_q - w_addend;
            else
                acc_d = acc_q + w_addend;
            q_d   = {1'b0, q_q[7:1]};
            cnt_d = cnt_q + 4'd1;
            if (w_last) begin
                pr_d    = acc_d;
                state_d = S_DONE;
            end
        end
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.mult_done  = (state_q == S_DONE);
    assign bus.step_count = cnt_q;
    assign bus.product    = pr_q;

endmodule

`default_nettype wire
